// File: rtl/scope_dac_pkg.sv
// -----------------------------------------------------------------------------
// scope_dac_pkg
// Shared types and helpers for the AD9708 transmit path.
//   state_t           : playback FSM states (IDLE, PRIME, RUN)
//   SAMPLE_W / CODE_W : native sample and DAC code widths
//   MIDSCALE          : offset-binary code for a zero-volt output
//   MIN_DIV           : smallest usable sample period in system clocks
//   to_offset_binary  : signed sample -> rounded, saturated offset-binary code
// -----------------------------------------------------------------------------
package scope_dac_pkg;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    RUN
  } state_t;

  localparam int SAMPLE_W = 12;
  localparam int CODE_W   = 8;

  localparam logic [CODE_W-1:0] MIDSCALE = CODE_W'(1 << (CODE_W - 1));
  localparam logic [15:0]       MIN_DIV  = 16'd2;

  // Half an output LSB, added before truncation so the result rounds to nearest.
  localparam int ROUND_BIAS = 1 << (SAMPLE_W - CODE_W - 1);
  localparam int SAT_MAX    = (1 << (SAMPLE_W - 1)) - 1;

  // The sum is formed one bit wider than the sample so the rounding bias
  // cannot wrap a large positive sample into a negative one. Only the
  // positive end can overflow, so only that end is clamped. Flipping the
  // top bit of the truncated two's-complement value yields offset binary.
  function automatic logic [CODE_W-1:0] to_offset_binary(input logic [SAMPLE_W-1:0] sample);
    logic [SAMPLE_W:0]   r;
    logic [CODE_W-1:0]   s;
    r = {sample[SAMPLE_W-1], sample} + (SAMPLE_W + 1)'(ROUND_BIAS);
    if (!r[SAMPLE_W] && r[SAMPLE_W-1]) begin
      r = (SAMPLE_W + 1)'(SAT_MAX);
    end
    s = r[SAMPLE_W-1 -: CODE_W];
    return {~s[CODE_W-1], s[CODE_W-2:0]};
  endfunction

endpackage

// File: rtl/scope_sync_fifo.sv
// -----------------------------------------------------------------------------
// scope_sync_fifo
// Single-clock sample buffer for the DAC drive path. The head word comes
// straight from the storage registers, so a word written on one edge is
// readable in the following cycle; there is no fall-through path, so a push
// into an empty FIFO is never visible in the same cycle.
//   clk   : system clock
//   rst   : synchronous active-high reset
//   clear : synchronous flush (pointers and count to zero)
//   push  : write wdata (ignored when full)
//   pop   : advance the head (ignored when empty)
//   wdata : word to store
//   rdata : current head word
//   full  : DEPTH words stored
//   empty : no words stored
//   count : number of words stored
// -----------------------------------------------------------------------------
module scope_sync_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign rdata   = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH
  // is a power of two.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: ;
      endcase
    end
  end

  // Storage needs no reset; stale words are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/ad9708_drive.sv
// -----------------------------------------------------------------------------
// ad9708_drive
// Buffers signed waveform samples from a valid/ready stream, converts them to
// offset binary and presents one code per programmable sample period to an
// AD9708 parallel DAC, together with the DAC latch clock.
//   i_clk           : system clock
//   i_rst           : synchronous active-high reset
//   i_enable        : 1 = play, 0 = stop and flush
//   i_cfg_div       : sample period in i_clk cycles (0..2 act as 2), latched on start
//   i_data/i_valid  : sample stream in; o_ready is the matching backpressure
//   o_dac_clk       : DAC latch clock, rising div/2 cycles after each data change
//   o_dac_data      : DAC code
//   o_busy          : playback active (not IDLE)
//   o_underflow_cnt : saturating count of sample slots that found the buffer empty
// -----------------------------------------------------------------------------
module ad9708_drive
  import scope_dac_pkg::*;
#(
  parameter int IN_W       = SAMPLE_W,
  parameter int DAC_W      = CODE_W,
  parameter int FIFO_DEPTH = 16,
  parameter int INVERT     = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_enable,
  input  logic [15:0]      i_cfg_div,
  input  logic [IN_W-1:0]  i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_dac_clk,
  output logic [DAC_W-1:0] o_dac_data,
  output logic             o_busy,
  output logic [15:0]      o_underflow_cnt
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [DAC_W-1:0] IDLE_CODE = (INVERT != 0) ? ~MIDSCALE : MIDSCALE;

  state_t           state;
  state_t           state_next;
  logic [15:0]      div;
  logic [15:0]      cnt;
  logic [IN_W-1:0]  head;
  logic [CW-1:0]    fifo_count;
  logic             full;
  logic             empty;
  logic             busy;
  logic             leaving;
  logic             strobe;
  logic             push;
  logic             pop;
  logic             starving;
  logic [DAC_W-1:0] code;

  scope_sync_fifo #(
    .WIDTH (IN_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (leaving),
    .push  (push),
    .pop   (pop),
    .wdata (i_data),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  // State register.
  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_next;
  end

  // Next state: prime until half the buffer is filled, so the producer has
  // slack before the first underflow can occur.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_enable) state_next = PRIME;
      PRIME: begin
        if (!i_enable)                                  state_next = IDLE;
        else if (fifo_count >= CW'(FIFO_DEPTH / 2))     state_next = RUN;
      end
      RUN:     if (!i_enable) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs. Dropping i_enable flushes the buffer and discards any
  // transfer offered in that same cycle.
  always_comb begin
    busy     = (state != IDLE);
    leaving  = busy && !i_enable;
    strobe   = (state == RUN) && i_enable && (cnt == 16'd0);
    push     = i_valid && busy && !full && !leaving;
    pop      = strobe && !empty;
    starving = strobe && empty;
  end

  assign o_busy  = busy;
  assign o_ready = busy && !full;
  assign code    = to_offset_binary(head) ^ {DAC_W{(INVERT != 0)}};

  // Period latch and phase counter; the period is frozen for a whole run.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      div <= MIN_DIV;
      cnt <= 16'd0;
    end else begin
      if (state == IDLE && i_enable) begin
        div <= (i_cfg_div < MIN_DIV) ? MIN_DIV : i_cfg_div;
      end
      if (state == RUN && state_next == RUN) begin
        cnt <= (cnt == div - 16'd1) ? 16'd0 : cnt + 16'd1;
      end else begin
        cnt <= 16'd0;
      end
    end
  end

  // DAC pins. The clock is low across the data update and rises halfway
  // through the period, giving the DAC div/2 cycles of setup.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_dac_clk  <= 1'b0;
      o_dac_data <= IDLE_CODE;
    end else begin
      o_dac_clk <= (state == RUN) && i_enable && (cnt >= (div >> 1));
      if (state != RUN || !i_enable) begin
        o_dac_data <= IDLE_CODE;
      end else if (pop) begin
        o_dac_data <= code;
      end
    end
  end

  // Underflow counter, cleared at the start of each run and held afterwards.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_underflow_cnt <= 16'd0;
    end else if (state == IDLE && i_enable) begin
      o_underflow_cnt <= 16'd0;
    end else if (starving && o_underflow_cnt != 16'hFFFF) begin
      o_underflow_cnt <= o_underflow_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ad9708_drive.sv
// -----------------------------------------------------------------------------
// tb_ad9708_drive
// Self-checking bench for ad9708_drive. Samples are offered through the
// valid/ready stream; every accepted sample is converted by an arithmetic
// reference (round to nearest 1/16, clamp, shift to offset binary) and queued.
// At each rising edge of the DAC clock the presented code must equal the next
// queued code, or the previous code when the queue is empty.
// -----------------------------------------------------------------------------
module tb_ad9708_drive;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [15:0] cfgDiv;
  logic [11:0] data;
  logic        valid;
  logic        ready;
  logic        dacClk;
  logic [7:0]  dacData;
  logic        busy;
  logic [15:0] underflowCnt;

  int errors = 0;
  int checks = 0;

  logic [11:0] pending[$];
  logic [7:0]  expQ[$];
  int          validPct = 100;
  int          divModel = 2;
  int          rises = 0;
  int          pushed = 0;
  int          cycle = 0;
  int          lastRise = 0;
  int          lowCnt = 0;
  bit          armed = 1'b0;
  bit          prevClk = 1'b0;
  logic [7:0]  lastCode = 8'h80;

  always #5 clk = ~clk;

  ad9708_drive #(
    .IN_W       (12),
    .DAC_W      (8),
    .FIFO_DEPTH (16),
    .INVERT     (0)
  ) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_enable        (enable),
    .i_cfg_div       (cfgDiv),
    .i_data          (data),
    .i_valid         (valid),
    .o_ready         (ready),
    .o_dac_clk       (dacClk),
    .o_dac_data      (dacData),
    .o_busy          (busy),
    .o_underflow_cnt (underflowCnt)
  );

  // Offset-binary code the DAC should show for a signed 12-bit sample.
  function automatic logic [7:0] modelCode(input logic [11:0] s);
    int v;
    v = int'($signed(s)) + 8;
    if (v > 2047) v = 2047;
    return 8'((v >>> 4) + 128);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One clock: account for the transfer offered before the edge, watch the
  // DAC clock, then offer the next pending sample.
  task automatic tick();
    bit         xfer;
    logic [7:0] want;
    xfer = valid && ready && enable;
    @(posedge clk);
    #1;
    cycle++;
    if (xfer) begin
      expQ.push_back(modelCode(data));
      pushed++;
      valid = 1'b0;
    end
    if (dacClk === 1'b1) begin
      if (!prevClk) begin
        rises++;
        if (expQ.size() > 0) want = expQ.pop_front();
        else                 want = lastCode;
        lastCode = want;
        checkOutput("dac_code_at_rise", 32'(dacData), 32'(want));
        if (armed) begin
          checkOutput("rise_period", cycle - lastRise, divModel);
          checkOutput("setup_cycles", lowCnt, divModel / 2);
        end
        armed    = 1'b1;
        lastRise = cycle;
      end
      lowCnt  = 0;
      prevClk = 1'b1;
    end else begin
      lowCnt++;
      prevClk = 1'b0;
    end
    if (!valid && pending.size() > 0 && $urandom_range(99) < validPct) begin
      data  = pending.pop_front();
      valid = 1'b1;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic runRises(input int n, input int budget);
    int start;
    int k;
    start = rises;
    k = 0;
    while (rises < start + n && k < budget) begin
      tick();
      k++;
    end
    checkOutput("rise_count", rises - start, n);
  endtask

  task automatic applyStimulus(input int count);
    for (int i = 0; i < count; i++) pending.push_back(12'($urandom()));
  endtask

  task automatic startPlay(input logic [15:0] div);
    cfgDiv   = div;
    enable   = 1'b1;
    divModel = (div < 2) ? 2 : int'(div);
    armed    = 1'b0;
    lowCnt   = 0;
    expQ.delete();
    tick();
  endtask

  task automatic stopPlay(input bit inFlight);
    enable = 1'b0;
    pending.delete();
    if (inFlight) begin
      data  = 12'h5A5;
      valid = 1'b1;
    end else begin
      valid = 1'b0;
    end
    tick();
    valid = 1'b0;
    checkOutput("stop_busy", 32'(busy), 0);
    checkOutput("stop_dac_data", 32'(dacData), 32'h80);
    checkOutput("stop_dac_clk", 32'(dacClk), 0);
    checkOutput("stop_ready", 32'(ready), 0);
    expQ.delete();
    armed = 1'b0;
  endtask

  initial begin
    int p0;
    int r0;
    rst    = 1'b1;
    enable = 1'b0;
    valid  = 1'b0;
    cfgDiv = 16'd4;
    data   = 12'h000;

    // Reset and idle state
    runCycles(3);
    rst = 1'b0;
    tick();
    checkOutput("reset_dac_data", 32'(dacData), 32'h80);
    checkOutput("reset_dac_clk", 32'(dacClk), 0);
    checkOutput("reset_ready", 32'(ready), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_underflow", 32'(underflowCnt), 0);

    // Prime threshold and conversion corners at div = 4
    $display("[TB] prime threshold and conversion");
    validPct = 100;
    startPlay(16'd4);
    pending = '{12'h7FF, 12'h800, 12'h000, 12'h007, 12'h008, 12'h7F9, 12'h100};
    runCycles(10);
    checkOutput("prime_busy", 32'(busy), 1);
    checkOutput("prime_dac_clk", 32'(dacClk), 0);
    checkOutput("prime_dac_data", 32'(dacData), 32'h80);
    checkOutput("prime_ready", 32'(ready), 1);
    data  = 12'hF00;
    valid = 1'b1;
    tick();
    checkOutput("eighth_push_dac_data", 32'(dacData), 32'h80);
    tick();
    checkOutput("run_entry_dac_data", 32'(dacData), 32'h80);
    tick();
    checkOutput("first_code_latency", 32'(dacData), 32'hFF);
    runRises(8, 100);
    checkOutput("conv_underflow", 32'(underflowCnt), 0);
    stopPlay(1'b0);

    // Underflow at div = 3: hold last code, one count per slot
    $display("[TB] underflow");
    applyStimulus(8);
    startPlay(16'd3);
    runRises(8, 100);
    checkOutput("uflow_last_code", 32'(dacData), 32'(lastCode));
    checkOutput("uflow_before", 32'(underflowCnt), 0);
    runCycles(60);
    checkOutput("uflow_after_60", 32'(underflowCnt), 20);
    checkOutput("uflow_hold_code", 32'(dacData), 32'(lastCode));
    stopPlay(1'b0);
    checkOutput("uflow_kept_idle", 32'(underflowCnt), 20);

    // Backpressure at div = 10 with an always-valid producer
    $display("[TB] backpressure");
    applyStimulus(40);
    startPlay(16'd10);
    checkOutput("uflow_cleared", 32'(underflowCnt), 0);
    p0 = pushed;
    r0 = rises;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (ready === 1'b0) break;
    end
    checkOutput("ready_dropped", 32'(ready), 0);
    checkOutput("stored_at_full", (pushed - p0) - (rises - r0), 16);
    runRises(40, 500);
    stopPlay(1'b0);

    // Stop with samples queued, then restart with div = 0 (acts as 2)
    $display("[TB] stop and restart");
    applyStimulus(8);
    startPlay(16'd10);
    runRises(3, 100);
    stopPlay(1'b1);
    applyStimulus(12);
    startPlay(16'd0);
    checkOutput("restart_underflow", 32'(underflowCnt), 0);
    runRises(12, 100);
    stopPlay(1'b0);

    // Random data with gappy producer; changing i_cfg_div mid-run is ignored
    $display("[TB] random playback");
    validPct = 70;
    applyStimulus(30);
    startPlay(16'($urandom_range(5, 8)));
    runRises(10, 200);
    cfgDiv = 16'd2;
    runRises(20, 400);
    stopPlay(1'b0);
    validPct = 100;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
